// File: rtl/seq_divider.sv
// Unsigned iterative restoring divider: one quotient bit per clock, with a
// start/busy/done handshake. Division by zero completes in one cycle.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom, so after WIDTH iterations this register holds the quotient.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    // The restored partial remainder is always below the divisor, so only the
    // shifted/trial values need the extra bit.
    logic [WIDTH-1:0] part_q, part_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             qbit_s;
    logic [WIDTH:0]   part_next_s;
    logic [WIDTH-1:0] dvd_next_s;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    always_comb begin
        shifted_s   = {part_q, dvd_q[WIDTH-1]};
        trial_s     = shifted_s - {1'b0, dvs_q};
        qbit_s      = ~trial_s[WIDTH];
        if (qbit_s) begin
            part_next_s = trial_s;
        end else begin
            part_next_s = shifted_s;
        end
        dvd_next_s  = {dvd_q[WIDTH-2:0], qbit_s};
    end

    // Next-state and datapath-load decisions for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    dvd_d  = i_dividend;
                    dvs_d  = i_divisor;
                    part_d = '0;
                    cnt_d  = '0;
                    if (i_divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = i_dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                dvd_d  = dvd_next_s;
                part_d = part_next_s[WIDTH-1:0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    quot_d  = dvd_next_s;
                    rem_d   = part_next_s[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, working and result registers; reset discards any division.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_quotient    = quot_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule
